// File: rtl/memshare_sched_ctrl.sv
// memShare scheduler control: sequences SCU.memShare() pipeline cycles over
// the allocation sequences, then drains, then pulses done.

package memShare_config_pkg;
  parameter int MAX_ALLOC_SEQ_NUM = 3;
endpackage

module memshare_sched_ctrl
  import memShare_config_pkg::*;
#(
  parameter int MAX_SEQ_NUM    = MAX_ALLOC_SEQ_NUM,
  parameter int PIPE_CYCLE_LEN = 4,
  parameter int DRAIN_LEN      = 2,
  localparam int SEQ_W         = $clog2(MAX_SEQ_NUM + 1)
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [SEQ_W-1:0] seq_last_i,
  input  logic             stall_i,
  input  logic             abort_i,
  output logic             ready_o,
  output logic             scu_memShare_busy_o,
  output logic             pipeCycle_begin_o,
  output logic             shiftGen_en_o,
  output logic [SEQ_W-1:0] seq_idx_o,
  output logic             done_o
);

  localparam int CNT_W = $clog2(PIPE_CYCLE_LEN);
  localparam int DRN_W = $clog2(DRAIN_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cyc_cnt;
  logic [CNT_W-1:0] w_cyc_nxt;
  logic [SEQ_W-1:0] r_seq_idx;
  logic [SEQ_W-1:0] w_seq_nxt;
  logic [SEQ_W-1:0] r_seq_last;
  logic [SEQ_W-1:0] w_last_nxt;
  logic [DRN_W-1:0] r_drn_cnt;
  logic [DRN_W-1:0] w_drn_nxt;
  logic             r_stall_q;
  logic [SEQ_W-1:0] w_seq_last_clamped;
  logic             w_begin;

  // Requested last sequence is clamped to what the configuration supports.
  assign w_seq_last_clamped = (seq_last_i > SEQ_W'(MAX_SEQ_NUM)) ? SEQ_W'(MAX_SEQ_NUM)
                                                                   : seq_last_i;

  // State and counter registers; everything here is control, so all of it resets.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cyc_cnt  <= '0;
      r_seq_idx  <= '0;
      r_seq_last <= '0;
      r_drn_cnt  <= '0;
      r_stall_q  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cyc_cnt  <= w_cyc_nxt;
      r_seq_idx  <= w_seq_nxt;
      r_seq_last <= w_last_nxt;
      r_drn_cnt  <= w_drn_nxt;
      r_stall_q  <= stall_i;
    end
  end

  // Next-state and counter update; abort is checked before stall so it wins.
  always_comb begin
    w_state_nxt = r_state;
    w_cyc_nxt   = r_cyc_cnt;
    w_seq_nxt   = r_seq_idx;
    w_last_nxt  = r_seq_last;
    w_drn_nxt   = r_drn_cnt;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nxt = S_RUN;
          w_cyc_nxt   = '0;
          w_seq_nxt   = '0;
          w_last_nxt  = w_seq_last_clamped;
        end
      end
      S_RUN: begin
        if (abort_i) begin
          w_state_nxt = S_IDLE;
          w_cyc_nxt   = '0;
          w_seq_nxt   = '0;
        end else if (!stall_i) begin
          if (r_cyc_cnt == CNT_W'(PIPE_CYCLE_LEN - 1)) begin
            w_cyc_nxt = '0;
            if (r_seq_idx == r_seq_last) begin
              w_state_nxt = S_DRAIN;
              w_drn_nxt   = '0;
            end else begin
              w_seq_nxt = r_seq_idx + SEQ_W'(1);
            end
          end else begin
            w_cyc_nxt = r_cyc_cnt + CNT_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (abort_i) begin
          w_state_nxt = S_IDLE;
          w_cyc_nxt   = '0;
          w_seq_nxt   = '0;
        end else if (r_drn_cnt == DRN_W'(DRAIN_LEN - 1)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_drn_nxt = r_drn_cnt + DRN_W'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_seq_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cyc_nxt   = '0;
        w_seq_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from registers only; a stall seen last cycle masks the begin marker.
  assign w_begin             = (r_state == S_RUN) && (r_cyc_cnt == '0) && !r_stall_q;
  assign ready_o             = (r_state == S_IDLE);
  assign scu_memShare_busy_o = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign pipeCycle_begin_o   = w_begin;
  assign shiftGen_en_o       = w_begin;
  assign seq_idx_o           = r_seq_idx;
  assign done_o              = (r_state == S_DONE);

endmodule

// File: tb/tb_memshare_sched_ctrl.sv
// Scoreboard bench for memshare_sched_ctrl: a progress-index reference model
// predicts every cycle's outputs; a monitor compares on the falling edge.
module tb_memshare_sched_ctrl;

  localparam int MAXS = 4;
  localparam int P    = 4;
  localparam int D    = 2;
  localparam int SW   = $clog2(MAXS + 1);

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;
  localparam int M_DONE  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [SW-1:0] seq_last_i;
  logic          stall_i;
  logic          abort_i;
  logic          ready_o;
  logic          busy_o;
  logic          begin_o;
  logic          shiftgen_o;
  logic [SW-1:0] seq_idx_o;
  logic          done_o;

  typedef struct packed {
    logic          rdy;
    logic          busy;
    logic          beg;
    logic          done;
    logic          chk_seq;
    logic [SW-1:0] seq;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model: linear progress k over N*P pipeline steps, plus drain countdown.
  int m_mode, m_k, m_total, m_last, m_dl;
  bit m_stq;

  always #5 clk = ~clk;

  memshare_sched_ctrl #(
    .MAX_SEQ_NUM   (MAXS),
    .PIPE_CYCLE_LEN(P),
    .DRAIN_LEN     (D)
  ) dut (
    .sys_clk            (clk),
    .rst                (rst),
    .start_i            (start_i),
    .seq_last_i         (seq_last_i),
    .stall_i            (stall_i),
    .abort_i            (abort_i),
    .ready_o            (ready_o),
    .scu_memShare_busy_o(busy_o),
    .pipeCycle_begin_o  (begin_o),
    .shiftGen_en_o      (shiftgen_o),
    .seq_idx_o          (seq_idx_o),
    .done_o             (done_o)
  );

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", nm, cyc, act, exp_v);
    end
  endtask

  // Monitor: each falling edge, pop the prediction for this cycle and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ready_o", int'(ready_o), int'(e.rdy));
        chk("busy_o", int'(busy_o), int'(e.busy));
        chk("pipeCycle_begin_o", int'(begin_o), int'(e.beg));
        chk("shiftGen_en_o", int'(shiftgen_o), int'(e.beg));
        chk("done_o", int'(done_o), int'(e.done));
        if (e.chk_seq) chk("seq_idx_o", int'(seq_idx_o), int'(e.seq));
        cyc++;
      end
    end
  end

  task automatic model_reset();
    m_mode = M_IDLE;
    m_k    = 0;
    m_dl   = 0;
    m_stq  = 1'b0;
  endtask

  // Push this cycle's expectation, apply inputs, advance the model, cross the edge.
  task automatic tick(input bit r, input bit s, input bit st, input bit ab, input int sl);
    exp_t e;
    e.rdy     = (m_mode == M_IDLE);
    e.busy    = (m_mode == M_RUN) || (m_mode == M_DRAIN);
    e.beg     = (m_mode == M_RUN) && ((m_k % P) == 0) && !m_stq;
    e.done    = (m_mode == M_DONE);
    e.chk_seq = (m_mode != M_DONE);
    e.seq     = (m_mode == M_RUN)   ? SW'(m_k / P) :
                (m_mode == M_DRAIN) ? SW'(m_last)  : SW'(0);
    q.push_back(e);

    rst        = r;
    start_i    = s;
    stall_i    = st;
    abort_i    = ab;
    seq_last_i = SW'(sl);

    if (r) begin
      model_reset();
    end else begin
      case (m_mode)
        M_IDLE: if (s) begin
          m_last  = (sl > MAXS) ? MAXS : sl;
          m_total = (m_last + 1) * P;
          m_k     = 0;
          m_mode  = M_RUN;
        end
        M_RUN: begin
          if (ab) m_mode = M_IDLE;
          else if (!st) begin
            if (m_k + 1 == m_total) begin
              m_mode = M_DRAIN;
              m_dl   = D;
            end else m_k++;
          end
        end
        M_DRAIN: begin
          if (ab) m_mode = M_IDLE;
          else if (m_dl == 1) m_mode = M_DONE;
          else m_dl--;
        end
        default: m_mode = M_IDLE;
      endcase
      m_stq = st;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; stall_i = 1'b0; abort_i = 1'b0; seq_last_i = '0;
    model_reset();
    m_last = 0; m_total = 0;
    repeat (2) @(posedge clk);
    #1;
    idle(2);

    // Two sequences, no stall: busy 10 cycles, done at +11.
    tick(0, 1, 0, 0, 1);
    idle(13);

    // Single sequence with a 3-cycle stall while cyc_cnt is 1.
    tick(0, 1, 0, 0, 0);
    idle(1);
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 0, 0);
    idle(8);

    // Abort during RUN.
    tick(0, 1, 0, 0, 3);
    idle(5);
    tick(0, 0, 0, 1, 0);
    idle(4);

    // Stall on a cycle-0 cycle, then abort together with stall.
    tick(0, 1, 0, 0, 2);
    tick(0, 0, 1, 0, 0);
    idle(3);
    tick(0, 0, 1, 1, 0);
    idle(3);

    // Start held high continuously.
    for (int i = 0; i < 40; i++) tick(0, 1, 0, 0, 1);
    idle(14);

    // Reset in DRAIN (with start and abort also high), then a clean run.
    tick(0, 1, 0, 0, 1);
    idle(9);
    tick(1, 1, 0, 1, 1);
    idle(2);
    tick(0, 1, 0, 0, 1);
    idle(13);

    // Requested last sequence above the limit is clamped.
    tick(0, 1, 0, 0, 7);
    idle(28);

    // Abort in DRAIN, abort while idle/done ignored.
    tick(0, 1, 0, 0, 0);
    idle(4);
    tick(0, 0, 0, 1, 0);
    tick(0, 0, 0, 1, 0);
    tick(0, 1, 0, 0, 0);
    idle(5);
    tick(0, 0, 0, 1, 0);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 59) == 0),
           int'($urandom_range(0, 7)));
    end
    idle(3);

    @(negedge clk);
    #1;
    if (q.size() != 0) chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
